// File: rtl/button_conditioner.sv
// Push-button conditioner: per-channel 2-flop synchronizer, tick-sampled saturating
// debouncer and rising-edge strobe. Channels share only the sample timer.
module button_conditioner #(
  parameter int unsigned N              = 1,
  parameter int unsigned SAMPLE_CNT_MAX = 25000,
  parameter int unsigned PULSE_CNT_MAX  = 150
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in_i,
  output logic [N-1:0] level_o,
  output logic [N-1:0] pulse_o
);

  localparam int unsigned TimerW = $clog2(SAMPLE_CNT_MAX);
  localparam int unsigned CntW   = $clog2(PULSE_CNT_MAX + 1);

  localparam logic [TimerW-1:0] TimerLast = TimerW'(SAMPLE_CNT_MAX - 1);
  localparam logic [CntW-1:0]   CntSat    = CntW'(PULSE_CNT_MAX);

  logic [N-1:0]           sync1_q, sync1_d;
  logic [N-1:0]           sync2_q, sync2_d;
  logic [TimerW-1:0]      timer_q, timer_d;
  logic                   tick;
  logic [N-1:0][CntW-1:0] cnt_q, cnt_d;
  logic [N-1:0]           level_prev_q, level_prev_d;

  always_comb begin
    sync1_d      = in_i;
    sync2_d      = sync1_q;
    tick         = (timer_q == TimerLast);
    timer_d      = tick ? '0 : timer_q + 1'b1;
    level_prev_d = level_o;
  end

  // A single low sample discards all accumulated credit; release is not debounced.
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < N; i++) begin
      if (!sync2_q[i]) begin
        cnt_d[i] = '0;
      end else if (tick && (cnt_q[i] < CntSat)) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    level_o = '0;
    for (int i = 0; i < N; i++) begin
      level_o[i] = (cnt_q[i] == CntSat);
    end
    pulse_o = level_o & ~level_prev_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      timer_q      <= '0;
      cnt_q        <= '0;
      level_prev_q <= '0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      timer_q      <= timer_d;
      cnt_q        <= cnt_d;
      level_prev_q <= level_prev_d;
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: expected strobes (mask and edge number since
// reset release) are queued when a press is driven and checked when a strobe appears.
module tb_button_conditioner;

  localparam int unsigned N = 2;
  localparam int unsigned S = 4;
  localparam int unsigned P = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] in_i;
  logic [N-1:0] level_o;
  logic [N-1:0] pulse_o;

  button_conditioner #(
    .N              (N),
    .SAMPLE_CNT_MAX (S),
    .PULSE_CNT_MAX  (P)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .in_i    (in_i),
    .level_o (level_o),
    .pulse_o (pulse_o)
  );

  always #5 clk = ~clk;

  // Rising edges since the last reset release; tick edges are the multiples of S.
  int unsigned ecnt;
  always @(posedge clk or posedge rst) begin
    if (rst) ecnt <= 0;
    else     ecnt <= ecnt + 1;
  end

  typedef struct {
    logic [N-1:0] mask;
    int unsigned  at_edge;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   pc0 = 0;
  int   pc1 = 0;
  int   lv0_cycles = 0;
  int   lv1_cycles = 0;

  always @(negedge clk) begin
    if (pulse_o[0] === 1'b1) pc0++;
    if (pulse_o[1] === 1'b1) pc1++;
    if (level_o[0] === 1'b1) lv0_cycles++;
    if (level_o[1] === 1'b1) lv1_cycles++;
  end

  // Input goes high after edge k: sync high from edge k+2, count advances on tick edges
  // from k+3 onward, saturation P-1 tick periods after the first one.
  function automatic int unsigned press_edge(input int unsigned k);
    int unsigned t = k + 3;
    while ((t % S) != 0) t++;
    return t + (P - 1) * S;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    in_i = 2'b11;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (level_o !== 2'b00 || pulse_o !== 2'b00) begin
        errors++;
        $display("FAIL reset_hold: level=%b pulse=%b expected 00/00", level_o, pulse_o);
      end
    end
    in_i = 2'b00;
    rst  = 1'b0;
    repeat (8) begin
      @(negedge clk);
      checks++;
      if (level_o !== 2'b00 || pulse_o !== 2'b00) begin
        errors++;
        $display("FAIL reset_release: level=%b pulse=%b expected 00/00", level_o, pulse_o);
      end
    end
  endtask

  task automatic test_clean_press();
    int b0, b1, l1;
    bit got;
    step();
    b0 = pc0; b1 = pc1; l1 = lv1_cycles;
    in_i[0] = 1'b1;
    exp_q.push_back('{mask: 2'b01, at_edge: press_edge(ecnt)});
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (pulse_o !== 2'b00) got = 1'b1;
    end
    e = exp_q.pop_front();
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL clean_press_timeout: no pulse, expected mask %b at edge %0d", e.mask, e.at_edge);
    end else if (pulse_o !== e.mask || ecnt != e.at_edge) begin
      errors++;
      $display("FAIL clean_press: pulse=%b at edge %0d, expected %b at edge %0d",
               pulse_o, ecnt, e.mask, e.at_edge);
    end
    @(negedge clk);
    checks++;
    if (pulse_o !== 2'b00 || level_o !== 2'b01) begin
      errors++;
      $display("FAIL clean_press_width: pulse=%b level=%b expected 00/01", pulse_o, level_o);
    end
    repeat (30) step();
    checks++;
    if (level_o !== 2'b01 || pc0 - b0 != 1 || pc1 != b1 || lv1_cycles != l1) begin
      errors++;
      $display("FAIL clean_press_hold: level=%b pulses0=%0d pulses1=%0d ch1_high=%0d expected 01/1/0/0",
               level_o, pc0 - b0, pc1 - b1, lv1_cycles - l1);
    end
  endtask

  task automatic test_release_repress();
    int base;
    bit got;
    step();
    base = pc0;
    in_i[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (level_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL release_early: level0=%b after 2 edges, expected 1", level_o[0]);
    end
    @(negedge clk);
    checks++;
    if (level_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL release_fall: level0=%b after 3 edges, expected 0", level_o[0]);
    end
    repeat (4) step();
    checks++;
    if (pc0 != base) begin
      errors++;
      $display("FAIL release_no_pulse: pulses=%0d expected 0", pc0 - base);
    end
    for (int p = 0; p < 3; p++) begin
      step();
      in_i[0] = 1'b1;
      exp_q.push_back('{mask: 2'b01, at_edge: press_edge(ecnt)});
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
        @(negedge clk);
        if (pulse_o !== 2'b00) got = 1'b1;
      end
      e = exp_q.pop_front();
      checks++;
      if (!got || pulse_o !== e.mask || ecnt != e.at_edge) begin
        errors++;
        $display("FAIL repress_%0d: got=%0d pulse=%b edge=%0d expected %b at edge %0d",
                 p, got, pulse_o, ecnt, e.mask, e.at_edge);
      end
      repeat (3) step();
      in_i[0] = 1'b0;
      repeat (5) step();
    end
    checks++;
    if (pc0 - base != 3) begin
      errors++;
      $display("FAIL event_count: increment=%0d expected 3", pc0 - base);
    end
  endtask

  task automatic test_glitch();
    int b0, l0;
    b0 = pc0;
    l0 = lv0_cycles;
    for (int r = 0; r < 6; r++) begin
      in_i[0] = 1'b1;
      repeat (5) step();
      in_i[0] = 1'b0;
      step();
    end
    repeat (4) step();
    checks++;
    if (pc0 != b0 || lv0_cycles != l0) begin
      errors++;
      $display("FAIL glitch: pulses=%0d level_high_cycles=%0d expected 0/0",
               pc0 - b0, lv0_cycles - l0);
    end
  endtask

  task automatic test_simultaneous();
    int b1;
    bit got;
    step();
    b1 = pc1;
    in_i = 2'b11;
    exp_q.push_back('{mask: 2'b11, at_edge: press_edge(ecnt)});
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (pulse_o !== 2'b00) got = 1'b1;
    end
    e = exp_q.pop_front();
    checks++;
    if (!got || pulse_o !== e.mask || ecnt != e.at_edge) begin
      errors++;
      $display("FAIL simultaneous: got=%0d pulse=%b edge=%0d expected %b at edge %0d",
               got, pulse_o, ecnt, e.mask, e.at_edge);
    end
    @(negedge clk);
    checks++;
    if (pulse_o !== 2'b00 || level_o !== 2'b11) begin
      errors++;
      $display("FAIL simultaneous_width: pulse=%b level=%b expected 00/11", pulse_o, level_o);
    end
    step();
    in_i = 2'b01;
    repeat (5) step();
    checks++;
    if (level_o !== 2'b01 || pc1 - b1 != 1) begin
      errors++;
      $display("FAIL release_ch1_only: level=%b pulses1=%0d expected 01/1", level_o, pc1 - b1);
    end
  endtask

  task automatic test_reset_mid_hold();
    int b0;
    bit got;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (level_o !== 2'b00 || pulse_o !== 2'b00) begin
      errors++;
      $display("FAIL async_reset: level=%b pulse=%b expected 00/00", level_o, pulse_o);
    end
    @(negedge clk);
    @(negedge clk);
    b0 = pc0;
    rst = 1'b0;
    exp_q.push_back('{mask: 2'b01, at_edge: press_edge(0)});
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (pulse_o !== 2'b00) got = 1'b1;
    end
    e = exp_q.pop_front();
    checks++;
    if (!got || pulse_o !== e.mask || ecnt != e.at_edge) begin
      errors++;
      $display("FAIL requalify: got=%0d pulse=%b edge=%0d expected %b at edge %0d",
               got, pulse_o, ecnt, e.mask, e.at_edge);
    end
    repeat (10) step();
    checks++;
    if (pc0 - b0 != 1 || level_o !== 2'b01) begin
      errors++;
      $display("FAIL requalify_once: pulses=%0d level=%b expected 1/01", pc0 - b0, level_o);
    end
  endtask

  initial begin
    rst  = 1'b1;
    in_i = 2'b11;
    test_reset();
    test_clean_press();
    test_release_repress();
    test_glitch();
    test_simultaneous();
    test_reset_mid_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
